// File: rtl/mdc_arbiter_if.sv
// Client request/response buses plus the link to the shared mdc GCD unit.
// slave = arbiter side, master = requesters, response consumer and mdc unit.
interface mdc_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [NUM_REQ*8-1:0] req_x_i;
  logic [NUM_REQ*8-1:0] req_y_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [IW-1:0]        rsp_id_o;
  logic [7:0]           rsp_dt_o;
  logic                 rsp_err_o;
  logic                 mdc_enb_o;
  logic [7:0]           mdc_dtx_o;
  logic [7:0]           mdc_dty_o;
  logic [7:0]           mdc_dt_i;
  logic                 mdc_busy_i;

  modport slave (
    input  req_valid_i, req_x_i, req_y_i, rsp_ready_i, mdc_dt_i, mdc_busy_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_dt_o, rsp_err_o,
           mdc_enb_o, mdc_dtx_o, mdc_dty_o
  );

  modport master (
    output req_valid_i, req_x_i, req_y_i, rsp_ready_i, mdc_dt_i, mdc_busy_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_dt_o, rsp_err_o,
           mdc_enb_o, mdc_dtx_o, mdc_dty_o
  );
endinterface

// File: rtl/mdc_arbiter.sv
// Round-robin sequencer sharing one mdc GCD unit among NUM_REQ requesters; one
// transaction in flight, watchdog converts a stalled unit into an error response.
module mdc_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  mdc_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  // One spare count so the compare cannot wrap when TIMEOUT is all-ones.
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [IW:0]   NR   = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] TO   = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] id_q;
  logic [7:0]    x_q;
  logic [7:0]    y_q;
  logic [7:0]    dt_q;
  logic          err_q;
  logic          enb_q;
  logic          rsp_vld_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [IW-1:0] ptr_d;
  logic          timeout_hit;
  logic          grant_found;
  logic [IW-1:0] grant_idx;
  logic [IW:0]   cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= NR) cand = cand - NR;
      if (!grant_found && bus.req_valid_i[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    bus.req_ready_o = '0;
    if (state_q == IDLE && grant_found) bus.req_ready_o[grant_idx] = 1'b1;
  end

  assign ptr_d       = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
  assign cnt_d       = cnt_q + 1'b1;
  assign timeout_hit = (cnt_d >= TO);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      dt_q      <= '0;
      err_q     <= 1'b0;
      enb_q     <= 1'b0;
      rsp_vld_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            x_q     <= bus.req_x_i[{grant_idx, 3'b000} +: 8];
            y_q     <= bus.req_y_i[{grant_idx, 3'b000} +: 8];
            id_q    <= grant_idx;
            ptr_q   <= ptr_d;
            enb_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          cnt_q <= cnt_d;
          if (bus.mdc_busy_i) begin
            enb_q   <= 1'b0;
            state_q <= WAIT_DONE;
          end else if (timeout_hit) begin
            enb_q     <= 1'b0;
            dt_q      <= '0;
            err_q     <= 1'b1;
            rsp_vld_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        WAIT_DONE: begin
          cnt_q <= cnt_d;
          // Completion is checked first so it wins a tie with the watchdog.
          if (!bus.mdc_busy_i) begin
            dt_q      <= bus.mdc_dt_i;
            err_q     <= 1'b0;
            rsp_vld_q <= 1'b1;
            state_q   <= RESP;
          end else if (timeout_hit) begin
            dt_q      <= '0;
            err_q     <= 1'b1;
            rsp_vld_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid_o = rsp_vld_q;
  assign bus.rsp_id_o    = id_q;
  assign bus.rsp_dt_o    = dt_q;
  assign bus.rsp_err_o   = err_q;
  assign bus.mdc_enb_o   = enb_q;
  assign bus.mdc_dtx_o   = x_q;
  assign bus.mdc_dty_o   = y_q;
endmodule

// File: tb/tb_mdc_arbiter.sv
// Directed bench for mdc_arbiter with a small behavioural mdc unit (busy for 3
// cycles after an enable rise); mode 1/2 pins busy low/high for watchdog cases.
module tb_mdc_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   mode   = 0;

  logic       m_busy;
  logic       m_enb_q;
  logic [1:0] m_cnt;
  logic [7:0] m_dt;

  mdc_arbiter_if #(.NUM_REQ(N)) bus ();

  mdc_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gcd8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a;
    y = b;
    while (y != 8'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  assign bus.mdc_busy_i = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : m_busy;
  assign bus.mdc_dt_i   = m_dt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy <= 1'b0; m_enb_q <= 1'b0; m_cnt <= 2'd0; m_dt <= 8'd0;
    end else begin
      m_enb_q <= bus.mdc_enb_o;
      if (m_busy) begin
        if (m_cnt == 2'd0) begin
          m_busy <= 1'b0;
          m_dt   <= gcd8(bus.mdc_dtx_o, bus.mdc_dty_o);
        end else m_cnt <= m_cnt - 2'd1;
      end else if (bus.mdc_enb_o && !m_enb_q) begin
        m_busy <= 1'b1;
        m_cnt  <= 2'd2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid_i = '0;
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid_i = '0; bus.req_x_i = '0; bus.req_y_i = '0; bus.rsp_ready_i = 1'b0;
    rstn = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (bus.req_ready_o !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready_o);
    end
    n_chk++;
    if ({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_dt_o, bus.rsp_err_o} !== 12'h000) begin
      n_fail++; $display("FAIL reset_rsp: vld=%b id=%0d dt=%0d err=%b want all 0",
                         bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_dt_o, bus.rsp_err_o);
    end
    n_chk++;
    if ({bus.mdc_enb_o, bus.mdc_dtx_o, bus.mdc_dty_o} !== 17'h0) begin
      n_fail++; $display("FAIL reset_mdc: enb=%b dtx=%0d dty=%0d want all 0",
                         bus.mdc_enb_o, bus.mdc_dtx_o, bus.mdc_dty_o);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int pulses, rsp_t;
    logic [10:0] r_rsp;
    logic [8:1]  enb_tr, vld_tr;
    logic [15:0] ops;
    pulses = 0; rsp_t = 0; r_rsp = '1; enb_tr = '0; vld_tr = '0;
    bus.rsp_ready_i = 1'b1;
    bus.req_x_i[7:0] = 8'd48; bus.req_y_i[7:0] = 8'd18; bus.req_valid_i = 4'b0001;
    #1;
    n_chk++;
    if (bus.req_ready_o !== 4'b0001) begin
      n_fail++; $display("FAIL single_grant: got %b want 0001", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = '0;
    ops = {bus.mdc_dtx_o, bus.mdc_dty_o};
    for (int t = 1; t <= 8; t++) begin
      if (bus.req_ready_o !== '0) pulses++;
      enb_tr[t] = bus.mdc_enb_o;
      vld_tr[t] = bus.rsp_valid_o;
      if (bus.rsp_valid_o === 1'b1 && rsp_t == 0) begin
        rsp_t = t;
        r_rsp = {bus.rsp_id_o, bus.rsp_dt_o, bus.rsp_err_o};
      end
      tick();
    end
    n_chk++;
    if (ops !== {8'd48, 8'd18}) begin
      n_fail++; $display("FAIL single_operands: got %h want 3012", ops);
    end
    n_chk++;
    if (enb_tr[3:1] !== 3'b011) begin
      n_fail++; $display("FAIL single_enb: cycles3..1 got %b want 011", enb_tr[3:1]);
    end
    n_chk++;
    if (vld_tr !== 8'b0010_0000) begin
      n_fail++; $display("FAIL single_rsp_timing: cycles8..1 got %b want 00100000", vld_tr);
    end
    n_chk++;
    if (r_rsp !== {2'd0, 8'd6, 1'b0}) begin
      n_fail++; $display("FAIL single_rsp: id/dt/err got %h want 00c", r_rsp);
    end
    n_chk++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL single_extra_ready: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_dt [4];
    exp_dt = '{8'd6, 8'd7, 8'd3, 8'd25};
    do_reset();
    bus.req_x_i = {8'd100, 8'd21, 8'd35, 8'd48};
    bus.req_y_i = {8'd75, 8'd6, 8'd14, 8'd18};
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      int g, w;
      g = i % 4;
      w = 0;
      while (bus.req_ready_o == '0 && w < 20) begin tick(); w++; end
      n_chk++;
      if (bus.req_ready_o !== (4'b0001 << g) || (i > 0 && w != 0)) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b after %0d idle cycles want %b after 0",
                           i, bus.req_ready_o, w, 4'b0001 << g);
      end
      tick();
      w = 0;
      while (bus.rsp_valid_o !== 1'b1 && w < 20) begin tick(); w++; end
      n_chk++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== g[1:0] ||
          bus.rsp_dt_o !== exp_dt[g] || bus.rsp_err_o !== 1'b0) begin
        n_fail++; $display("FAIL rr_rsp[%0d]: vld=%b id=%0d dt=%0d err=%b want 1 %0d %0d 0",
                           i, bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_dt_o, bus.rsp_err_o,
                           g, exp_dt[g]);
      end
      tick();
    end
    bus.req_valid_i = '0;
  endtask

  task automatic test_skip();
    int w;
    do_reset();
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = 4'b0100;
    #1;
    n_chk++;
    if (bus.req_ready_o !== 4'b0100) begin
      n_fail++; $display("FAIL skip_first: got %b want 0100", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = '0;
    w = 0;
    while (bus.rsp_valid_o !== 1'b1 && w < 20) begin tick(); w++; end
    tick();
    bus.req_valid_i = 4'b1001;
    #1;
    n_chk++;
    if (bus.req_ready_o !== 4'b1000) begin
      n_fail++; $display("FAIL skip_next: got %b want 1000", bus.req_ready_o);
    end
    bus.req_valid_i = '0;
  endtask

  task automatic test_backpressure();
    int w, bad;
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 4'b0010;
    #1;
    n_chk++;
    if (bus.req_ready_o !== 4'b0010) begin
      n_fail++; $display("FAIL bp_grant: got %b want 0010", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 4'b1111;
    w = 0;
    while (bus.rsp_valid_o !== 1'b1 && w < 20) begin tick(); w++; end
    bad = (w >= 20) ? 1 : 0;
    for (int t = 0; t < 10; t++) begin
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 2'd1 || bus.rsp_dt_o !== 8'd7 ||
          bus.mdc_dtx_o !== 8'd35 || bus.req_ready_o !== 4'b0000) bad++;
      tick();
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL bp_hold: %0d unstable cycles want 0 (vld=%b id=%0d dt=%0d)",
                         bad, bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_dt_o);
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    n_chk++;
    if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 4'b0100) begin
      n_fail++; $display("FAIL bp_release: vld=%b ready=%b want 0 0100",
                         bus.rsp_valid_o, bus.req_ready_o);
    end
    bus.req_valid_i = '0;
  endtask

  task automatic test_timeout();
    for (int m = 1; m <= 2; m++) begin
      int t;
      logic [3:0] sel;
      sel = (m == 1) ? 4'b0100 : 4'b1000;
      mode = m;
      bus.rsp_ready_i = 1'b1;
      bus.req_valid_i = sel;
      #1;
      tick();
      bus.req_valid_i = '0;
      t = 1;
      while (bus.rsp_valid_o !== 1'b1 && t < 30) begin tick(); t++; end
      n_chk++;
      if (t != TO + 2 || bus.rsp_err_o !== 1'b1 || bus.rsp_dt_o !== 8'd0 ||
          bus.rsp_id_o !== ((m == 1) ? 2'd2 : 2'd3)) begin
        n_fail++; $display("FAIL timeout_mode%0d: at +%0d err=%b dt=%0d id=%0d want +%0d 1 0 %0d",
                           m, t, bus.rsp_err_o, bus.rsp_dt_o, bus.rsp_id_o, TO + 2, m + 1);
      end
      tick();
    end
    mode = 0;
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = 4'b1000;
    #1;
    tick();
    bus.req_valid_i = '0;
    repeat (2) tick();
    rstn = 1'b0;
    #1;
    n_chk++;
    if ({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_dt_o, bus.rsp_err_o,
         bus.mdc_enb_o, bus.mdc_dtx_o, bus.mdc_dty_o} !== 33'h0) begin
      n_fail++; $display("FAIL midreset_async: rdy=%b vld=%b id=%0d dt=%0d enb=%b dtx=%0d want all 0",
                         bus.req_ready_o, bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_dt_o,
                         bus.mdc_enb_o, bus.mdc_dtx_o);
    end
    repeat (2) tick();
    rstn = 1'b1;
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      if (bus.rsp_valid_o !== 1'b0) seen++;
      tick();
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL midreset_stale: %0d response cycles want 0", seen);
    end
    bus.req_valid_i = 4'b1111;
    #1;
    n_chk++;
    if (bus.req_ready_o !== 4'b0001) begin
      n_fail++; $display("FAIL midreset_grant: got %b want 0001", bus.req_ready_o);
    end
    bus.req_valid_i = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/mdc_arbiter.md
# mdc_arbiter

Round-robin arbiter and sequencer that shares one `mdc` GCD unit (8-bit operands) between `NUM_REQ` independent requesters. It accepts one request at a time, drives the `mdc` start and operand inputs, and waits for the unit to finish. It then returns the result tagged with the requester index. A watchdog aborts transactions that never complete. It sits between the client-facing request buses and a single `mdc` instance.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 1023: maximum cycles spent in WAIT_BUSY + WAIT_DONE before abort, ≥ 4.
- `clk_i` in 1: clock. One clock domain; all logic rising-edge.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `req_valid_i` in `NUM_REQ`: request valid per requester.
- `req_ready_o` out `NUM_REQ`: one-hot accept; request k is taken when `req_valid_i[k] & req_ready_o[k]`.
- `req_x_i` in `NUM_REQ*8`: operand X; requester k uses bits `[8k+7:8k]`.
- `req_y_i` in `NUM_REQ*8`: operand Y, same packing as `req_x_i`.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumer ready.
- `rsp_id_o` out `$clog2(NUM_REQ)`: index of the requester being answered.
- `rsp_dt_o` out 8: GCD result.
- `rsp_err_o` out 1: transaction aborted by the watchdog.
- `mdc_enb_o` out 1: drives `mdc` `enb_i`.
- `mdc_dtx_o` out 8: drives `mdc` `dtx_i`.
- `mdc_dty_o` out 8: drives `mdc` `dty_i`.
- `mdc_dt_i` in 8: from `mdc` `dt_o`.
- `mdc_busy_i` in 1: from `mdc` `busy_o`.

## Operation
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP. Reset state is IDLE.
- **IDLE:**
  - Scan `req_valid_i` starting at priority pointer `ptr`, wrapping modulo `NUM_REQ`. The first valid index g is granted.
  - `req_ready_o = onehot(g)` combinationally, only in IDLE and only if any request is valid; otherwise all zero.
  - On accept, latch X, Y and g; set `ptr <= (g+1) mod NUM_REQ`; go to ISSUE.
- **ISSUE:** assert `mdc_enb_o`; clear the watchdog counter; go to WAIT_BUSY.
- **WAIT_BUSY:**
  - Keep `mdc_enb_o` high and increment the counter.
  - If `mdc_busy_i == 1`, go to WAIT_DONE.
  - If the counter reaches `TIMEOUT`, abort.
- **WAIT_DONE:**
  - `mdc_enb_o` is low; increment the counter.
  - When `mdc_busy_i == 0`, capture `mdc_dt_i` into the result register, set err to 0 and go to RESP.
  - If the counter reaches `TIMEOUT` first, abort.
  - If busy falls in the same cycle the counter hits `TIMEOUT`, completion wins (err=0).
- **Abort:** result=0, err=1, go to RESP.
- **RESP:**
  - `rsp_valid_o = 1`, with `rsp_id_o`, `rsp_dt_o` and `rsp_err_o` driven from registers and stable until handshake.
  - On `rsp_ready_i`, go to IDLE.
- **Operand drive:**
  - `mdc_dtx_o` and `mdc_dty_o` are driven from the latched operands and held stable from ISSUE through RESP.
  - They are 0 only after reset, before the first grant.
- **Fairness:** a requester that keeps `req_valid_i` high waits at most `NUM_REQ-1` other transactions.
- **No reordering:** only one transaction is in flight; `req_valid_i` changes outside IDLE are ignored.
- **Reset mid-operation:** returns to IDLE immediately and drops the in-flight transaction with no response. Registers clear to 0, `ptr=0`.

## Timing
- **Reset values:**
  - `req_ready_o=0` (`req_valid_i` is low during reset).
  - `rsp_valid_o=0`, `rsp_id_o=0`, `rsp_dt_o=0`, `rsp_err_o=0`.
  - `mdc_enb_o=0`, `mdc_dtx_o=0`, `mdc_dty_o=0`.
- **Accept:** request accepted at cycle A (IDLE). `mdc_enb_o` is high from A+1.
- **Busy seen:** if `mdc_busy_i` is seen high at cycle B, `mdc_enb_o` drops at B+1.
- **Completion:** first cycle C with busy low in WAIT_DONE. `rsp_valid_o` rises at C+1.
- **Back-to-back:** handshake at cycle R; the next grant is possible at R+1 (IDLE).
- **Minimum accept-to-next-accept:** 5 cycles.
- **Watchdog:** abort response appears `TIMEOUT+2` cycles after accept when busy never rises.

## Test plan
- Single requester 0, X=48, Y=18, `rsp_ready_i=1` → one `req_ready_o[0]` pulse; `rsp_valid_o` with id=0, dt=6, err=0; `mdc_enb_o` deasserted after busy seen.
- All four requesters valid continuously with distinct operands, e.g. req1 X=35, Y=14 → grants in order 0,1,2,3,0; responses carry matching ids, e.g. id=1 dt=7.
- After a grant to 2, only requesters 0 and 3 valid → next grant goes to 3, not 0.
- Response backpressure: `rsp_ready_i=0` for 10 cycles → `rsp_valid_o`, id, dt and `mdc_dtx_o` stay stable; no `req_ready_o` asserted; release → IDLE next cycle.
- `mdc_busy_i` forced 0, `TIMEOUT=8` → response with err=1 and dt=0 at 10 cycles after accept. Separately, busy forced 1 → err=1 after `TIMEOUT`.
- Assert `rstn_i` low in WAIT_DONE → all outputs reset asynchronously; after release, no stale response and the first grant goes to requester 0.
